// File: rtl/vtage_ud_ctrl.sv
`timescale 1ns/1ps
// VTAGE bank update controller: in-order feedback FIFO decoded into per-entry ud_* strobes; build option VTAGE_U_DECAY_EN adds a usefulness-decay walk.
// Latency: ud_* registered, one cycle after enqueue when the FIFO is empty; up to P_NUM_PRED records per cycle, never two on one index.
// Backpressure: cm_ready_o low when fewer than P_NUM_PRED slots are free; lanes offered then are dropped and must be held by the sender.
module vtage_ud_ctrl #(
    parameter int P_NUM_PRED    = 2,
    parameter int P_NUM_ENTRIES = 256,
    parameter int P_TAG_WIDTH   = 8,
    parameter int P_VALUE_WIDTH = 32,
    parameter int P_FIFO_DEPTH  = 8,
    parameter int P_DECAY_LOG2  = 8,
    localparam int LP_INDEX_WIDTH = $clog2(P_NUM_ENTRIES)
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [P_NUM_PRED-1:0]                   cm_valid_i,
    output logic                                    cm_ready_o,
    input  logic [P_NUM_PRED*LP_INDEX_WIDTH-1:0]    cm_index_i,
    input  logic [P_NUM_PRED*P_TAG_WIDTH-1:0]       cm_tag_i,
    input  logic [P_NUM_PRED-1:0]                   cm_hit_i,
    input  logic [P_NUM_PRED-1:0]                   cm_correct_i,
    input  logic [P_NUM_PRED-1:0]                   cm_alloc_i,
    input  logic [P_NUM_PRED*P_VALUE_WIDTH-1:0]     cm_value_i,
    output logic [P_NUM_PRED*LP_INDEX_WIDTH-1:0]    ud_index_o,
    output logic [P_NUM_PRED-1:0]                   ud_incr_conf_o,
    output logic [P_NUM_PRED-1:0]                   ud_rst_conf_o,
    output logic [P_NUM_PRED-1:0]                   ud_incr_use_o,
    output logic [P_NUM_PRED-1:0]                   ud_decr_use_o,
    output logic [P_NUM_PRED-1:0]                   ud_rst_use_o,
    output logic [P_NUM_PRED-1:0]                   ud_load_tag_o,
    output logic [P_NUM_PRED-1:0]                   ud_load_value_o,
    output logic [P_NUM_PRED*P_TAG_WIDTH-1:0]       ud_tag_o,
    output logic [P_NUM_PRED*P_VALUE_WIDTH-1:0]     ud_value_o,
    output logic                                    busy_o
);
    localparam int LP_PTR_W = $clog2(P_FIFO_DEPTH);
    localparam int LP_CNT_W = LP_PTR_W + 1;

    typedef struct packed {
        logic [LP_INDEX_WIDTH-1:0] index;
        logic [P_TAG_WIDTH-1:0]    tag;
        logic                      hit;
        logic                      correct;
        logic                      alloc;
        logic [P_VALUE_WIDTH-1:0]  value;
    } rec_t;

    typedef enum logic {S_IDLE, S_DECAY} state_t;

    rec_t                      fifo_q [P_FIFO_DEPTH];
    rec_t                      in_rec [P_NUM_PRED];
    rec_t                      rd_rec [P_NUM_PRED];
    logic [LP_PTR_W-1:0]       wr_slot [P_NUM_PRED];
    logic [LP_PTR_W-1:0]       rd_ptr_q;
    logic [LP_PTR_W-1:0]       wr_ptr_q;
    logic [LP_CNT_W-1:0]       count_q;
    logic [LP_CNT_W-1:0]       enq_cnt;
    logic [LP_CNT_W-1:0]       deq_cnt;
    logic [P_NUM_PRED-1:0]     wr_en;
    logic [P_NUM_PRED-1:0]     take;
    logic                      stop;
    logic                      conflict;
    state_t                    state_q;
    logic [LP_INDEX_WIDTH-1:0] walk_ptr_q;

    logic [P_NUM_PRED*LP_INDEX_WIDTH-1:0] index_d;
    logic [P_NUM_PRED*P_TAG_WIDTH-1:0]    tag_d;
    logic [P_NUM_PRED*P_VALUE_WIDTH-1:0]  value_d;
    logic [P_NUM_PRED-1:0] incr_conf_d, rst_conf_d, incr_use_d, decr_use_d;
    logic [P_NUM_PRED-1:0] rst_use_d, load_tag_d, load_value_d;

    assign cm_ready_o = (LP_CNT_W'(P_FIFO_DEPTH) - count_q) >= LP_CNT_W'(P_NUM_PRED);
    assign busy_o     = (count_q != '0) || (state_q == S_DECAY);

    // Valid lanes are packed into consecutive slots in ascending lane order.
    always_comb begin
        enq_cnt = '0;
        wr_en   = '0;
        for (int j = 0; j < P_NUM_PRED; j++) begin
            in_rec[j].index   = cm_index_i[j*LP_INDEX_WIDTH +: LP_INDEX_WIDTH];
            in_rec[j].tag     = cm_tag_i[j*P_TAG_WIDTH +: P_TAG_WIDTH];
            in_rec[j].hit     = cm_hit_i[j];
            in_rec[j].correct = cm_correct_i[j];
            in_rec[j].alloc   = cm_alloc_i[j];
            in_rec[j].value   = cm_value_i[j*P_VALUE_WIDTH +: P_VALUE_WIDTH];
            wr_en[j]          = cm_valid_i[j] & cm_ready_o;
            wr_slot[j]        = wr_ptr_q + enq_cnt[LP_PTR_W-1:0];
            if (wr_en[j]) begin
                enq_cnt = enq_cnt + LP_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int j = 0; j < P_NUM_PRED; j++) begin
            if (wr_en[j]) begin
                fifo_q[wr_slot[j]] <= in_rec[j];
            end
        end
    end

    // Group stops at the first record repeating an earlier index; that record leads next cycle.
    always_comb begin
        take     = '0;
        deq_cnt  = '0;
        stop     = 1'b0;
        conflict = 1'b0;
        for (int j = 0; j < P_NUM_PRED; j++) begin
            rd_rec[j] = fifo_q[rd_ptr_q + LP_PTR_W'(j)];
        end
        for (int j = 0; j < P_NUM_PRED; j++) begin
            conflict = 1'b0;
            for (int i = 0; i < j; i++) begin
                if (rd_rec[i].index == rd_rec[j].index) begin
                    conflict = 1'b1;
                end
            end
            if ((state_q != S_IDLE) || (LP_CNT_W'(j) >= count_q) || conflict) begin
                stop = 1'b1;
            end
            if (!stop) begin
                take[j] = 1'b1;
                deq_cnt = deq_cnt + LP_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_q + deq_cnt[LP_PTR_W-1:0];
            wr_ptr_q <= wr_ptr_q + enq_cnt[LP_PTR_W-1:0];
            count_q  <= count_q + enq_cnt - deq_cnt;
        end
    end

    always_comb begin
        index_d      = '0;
        tag_d        = '0;
        value_d      = '0;
        incr_conf_d  = '0;
        rst_conf_d   = '0;
        incr_use_d   = '0;
        decr_use_d   = '0;
        rst_use_d    = '0;
        load_tag_d   = '0;
        load_value_d = '0;
        if (state_q == S_DECAY) begin
            for (int j = 0; j < P_NUM_PRED; j++) begin
                index_d[j*LP_INDEX_WIDTH +: LP_INDEX_WIDTH] = walk_ptr_q + LP_INDEX_WIDTH'(j);
                decr_use_d[j] = 1'b1;
            end
        end else begin
            for (int j = 0; j < P_NUM_PRED; j++) begin
                if (take[j]) begin
                    index_d[j*LP_INDEX_WIDTH +: LP_INDEX_WIDTH] = rd_rec[j].index;
                    if (rd_rec[j].hit) begin
                        if (rd_rec[j].correct) begin
                            incr_conf_d[j] = 1'b1;
                            incr_use_d[j]  = 1'b1;
                        end else begin
                            rst_conf_d[j]   = 1'b1;
                            decr_use_d[j]   = 1'b1;
                            load_value_d[j] = 1'b1;
                            value_d[j*P_VALUE_WIDTH +: P_VALUE_WIDTH] = rd_rec[j].value;
                        end
                    end else if (rd_rec[j].alloc) begin
                        load_tag_d[j]   = 1'b1;
                        load_value_d[j] = 1'b1;
                        rst_conf_d[j]   = 1'b1;
                        rst_use_d[j]    = 1'b1;
                        tag_d[j*P_TAG_WIDTH +: P_TAG_WIDTH]       = rd_rec[j].tag;
                        value_d[j*P_VALUE_WIDTH +: P_VALUE_WIDTH] = rd_rec[j].value;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ud_index_o      <= '0;
            ud_tag_o        <= '0;
            ud_value_o      <= '0;
            ud_incr_conf_o  <= '0;
            ud_rst_conf_o   <= '0;
            ud_incr_use_o   <= '0;
            ud_decr_use_o   <= '0;
            ud_rst_use_o    <= '0;
            ud_load_tag_o   <= '0;
            ud_load_value_o <= '0;
        end else begin
            ud_index_o      <= index_d;
            ud_tag_o        <= tag_d;
            ud_value_o      <= value_d;
            ud_incr_conf_o  <= incr_conf_d;
            ud_rst_conf_o   <= rst_conf_d;
            ud_incr_use_o   <= incr_use_d;
            ud_decr_use_o   <= decr_use_d;
            ud_rst_use_o    <= rst_use_d;
            ud_load_tag_o   <= load_tag_d;
            ud_load_value_o <= load_value_d;
        end
    end

`ifdef VTAGE_U_DECAY_EN
    state_t                    state_d;
    logic [P_DECAY_LOG2-1:0]   decay_cnt_q;
    logic [P_DECAY_LOG2:0]     decay_sum;
    logic [LP_INDEX_WIDTH-1:0] walk_ptr_d;

    // Carry out of the allocation counter starts a walk over every entry.
    always_comb begin
        decay_sum  = {1'b0, decay_cnt_q};
        state_d    = state_q;
        walk_ptr_d = walk_ptr_q;
        for (int j = 0; j < P_NUM_PRED; j++) begin
            if (take[j] && !rd_rec[j].hit && rd_rec[j].alloc) begin
                decay_sum = decay_sum + (P_DECAY_LOG2+1)'(1);
            end
        end
        case (state_q)
            S_IDLE: begin
                if (decay_sum[P_DECAY_LOG2]) begin
                    state_d    = S_DECAY;
                    walk_ptr_d = '0;
                end
            end
            S_DECAY: begin
                walk_ptr_d = walk_ptr_q + LP_INDEX_WIDTH'(P_NUM_PRED);
                if (walk_ptr_q == LP_INDEX_WIDTH'(P_NUM_ENTRIES - P_NUM_PRED)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            walk_ptr_q  <= '0;
            decay_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            walk_ptr_q  <= walk_ptr_d;
            decay_cnt_q <= decay_sum[P_DECAY_LOG2-1:0];
        end
    end
`else
    assign state_q    = S_IDLE;
    assign walk_ptr_q = '0;
`endif

endmodule

// File: tb/tb_vtage_ud_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for vtage_ud_ctrl: directed vectors push expected ud_* snapshots; a monitor pops one per non-idle output cycle.
module tb_vtage_ud_ctrl;
    localparam int NP = 2;
    localparam int IW = 8;
    localparam int TW = 8;
    localparam int VW = 32;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [NP-1:0]     cm_valid_i;
    logic              cm_ready_o;
    logic [NP*IW-1:0]  cm_index_i;
    logic [NP*TW-1:0]  cm_tag_i;
    logic [NP-1:0]     cm_hit_i, cm_correct_i, cm_alloc_i;
    logic [NP*VW-1:0]  cm_value_i;
    logic [NP*IW-1:0]  ud_index_o;
    logic [NP-1:0]     ud_incr_conf_o, ud_rst_conf_o, ud_incr_use_o, ud_decr_use_o;
    logic [NP-1:0]     ud_rst_use_o, ud_load_tag_o, ud_load_value_o;
    logic [NP*TW-1:0]  ud_tag_o;
    logic [NP*VW-1:0]  ud_value_o;
    logic              busy_o;

    vtage_ud_ctrl #(
        .P_NUM_PRED(NP), .P_NUM_ENTRIES(256), .P_TAG_WIDTH(TW),
        .P_VALUE_WIDTH(VW), .P_FIFO_DEPTH(8), .P_DECAY_LOG2(2)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cm_valid_i(cm_valid_i), .cm_ready_o(cm_ready_o),
        .cm_index_i(cm_index_i), .cm_tag_i(cm_tag_i), .cm_hit_i(cm_hit_i),
        .cm_correct_i(cm_correct_i), .cm_alloc_i(cm_alloc_i), .cm_value_i(cm_value_i),
        .ud_index_o(ud_index_o), .ud_incr_conf_o(ud_incr_conf_o), .ud_rst_conf_o(ud_rst_conf_o),
        .ud_incr_use_o(ud_incr_use_o), .ud_decr_use_o(ud_decr_use_o), .ud_rst_use_o(ud_rst_use_o),
        .ud_load_tag_o(ud_load_tag_o), .ud_load_value_o(ud_load_value_o),
        .ud_tag_o(ud_tag_o), .ud_value_o(ud_value_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [NP*IW-1:0] idx;
        logic [NP-1:0]    ic, rc, iu, du, ru, lt, lv;
        logic [NP*TW-1:0] tag;
        logic [NP*VW-1:0] val;
    } snap_t;

    snap_t sb[$];
    snap_t e, act, exp_s;
    int    errors = 0;
    int    checks = 0;
    int    ec, seq, dq;
    logic  rm;

    function automatic snap_t snap_now();
        snap_t s;
        s.idx = ud_index_o;    s.ic = ud_incr_conf_o; s.rc = ud_rst_conf_o;
        s.iu  = ud_incr_use_o; s.du = ud_decr_use_o;  s.ru = ud_rst_use_o;
        s.lt  = ud_load_tag_o; s.lv = ud_load_value_o;
        s.tag = ud_tag_o;      s.val = ud_value_o;
        return s;
    endfunction

    // Expected decode of one record onto output lane j of the snapshot being built.
    function automatic void put(int j, logic [7:0] idx, logic [7:0] tag, logic hit,
                                logic cor, logic al, logic [31:0] val);
        e.idx[j*IW +: IW] = idx;
        if (hit && cor) begin
            e.ic[j] = 1'b1; e.iu[j] = 1'b1;
        end else if (hit) begin
            e.rc[j] = 1'b1; e.du[j] = 1'b1; e.lv[j] = 1'b1; e.val[j*VW +: VW] = val;
        end else if (al) begin
            e.lt[j] = 1'b1; e.lv[j] = 1'b1; e.rc[j] = 1'b1; e.ru[j] = 1'b1;
            e.tag[j*TW +: TW] = tag; e.val[j*VW +: VW] = val;
        end
    endfunction

    task automatic drv(int j, logic [7:0] idx, logic [7:0] tag, logic hit,
                       logic cor, logic al, logic [31:0] val);
        cm_valid_i[j] = 1'b1;
        cm_index_i[j*IW +: IW] = idx;
        cm_tag_i[j*TW +: TW]   = tag;
        cm_hit_i[j] = hit; cm_correct_i[j] = cor; cm_alloc_i[j] = al;
        cm_value_i[j*VW +: VW] = val;
    endtask

    task automatic step();
        @(posedge clk_i); #1;
        cm_valid_i = '0;
    endtask

    task automatic chk(string name, logic [127:0] a, logic [127:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, a, x);
        end
    endtask

    task automatic drain(string name, int budget);
        for (int c = 0; c < budget && sb.size() != 0; c++) @(posedge clk_i);
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain act=%0d pending exp=0", name, sb.size());
        end
    endtask

    task automatic mon();
        if (rst_ni) begin
            act = snap_now();
            if (act != '0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL out_unexpected act=%h exp=none", act);
                end else begin
                    exp_s = sb.pop_front();
                    if (act !== exp_s) begin
                        errors++;
                        $display("FAIL out_cmp act=%h exp=%h", act, exp_s);
                    end
                end
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1);
    end

    initial begin
        cm_valid_i = '0; cm_index_i = '0; cm_tag_i = '0; cm_hit_i = '0;
        cm_correct_i = '0; cm_alloc_i = '0; cm_value_i = '0;
        fork
            forever begin
                @(negedge clk_i);
                mon();
            end
        join_none

        // Reset held with both lanes offered.
        rst_ni = 1'b0;
        drv(0, 8'd1, 8'h11, 1'b1, 1'b1, 1'b0, 32'h1);
        drv(1, 8'd2, 8'h22, 1'b0, 1'b0, 1'b1, 32'h2);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_ud", 128'(snap_now()), 128'd0);
        chk("rst_ready", 128'(cm_ready_o), 128'd1);
        chk("rst_busy", 128'(busy_o), 128'd0);
        cm_valid_i = '0;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk("post_rst_busy", 128'(busy_o), 128'd0);
        chk("post_rst_ready", 128'(cm_ready_o), 128'd1);

        // Two hits on distinct indices.
        e = '0; put(0, 8'd5, 8'h0, 1'b1, 1'b1, 1'b0, 32'h0); put(1, 8'd9, 8'h0, 1'b1, 1'b0, 1'b0, 32'hDEAD); sb.push_back(e);
        drv(0, 8'd5, 8'h0, 1'b1, 1'b1, 1'b0, 32'h0);
        drv(1, 8'd9, 8'h0, 1'b1, 1'b0, 1'b0, 32'hDEAD);
        step();
        chk("busy_after_enq", 128'(busy_o), 128'd1);
        drain("hits", 10);

        // Same-index pair serialises over two cycles.
        e = '0; put(0, 8'd3, 8'h0, 1'b1, 1'b1, 1'b0, 32'h0); sb.push_back(e);
        e = '0; put(0, 8'd3, 8'h0, 1'b1, 1'b0, 1'b0, 32'h11); sb.push_back(e);
        drv(0, 8'd3, 8'h0, 1'b1, 1'b1, 1'b0, 32'h0);
        drv(1, 8'd3, 8'h0, 1'b1, 1'b0, 1'b0, 32'h11);
        step();
        drain("conflict", 10);

        // Lane 1 only: compacted onto output lane 0.
        e = '0; put(0, 8'd40, 8'h0, 1'b1, 1'b1, 1'b0, 32'h0); sb.push_back(e);
        drv(1, 8'd40, 8'h0, 1'b1, 1'b1, 1'b0, 32'h0);
        step();
        drain("compact", 10);

        // Allocation plus a consumed no-alloc miss.
        e = '0; put(0, 8'd12, 8'hA5, 1'b0, 1'b0, 1'b1, 32'h7); put(1, 8'd20, 8'h0, 1'b0, 1'b0, 1'b0, 32'h0); sb.push_back(e);
        drv(0, 8'd12, 8'hA5, 1'b0, 1'b0, 1'b1, 32'h7);
        drv(1, 8'd20, 8'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        drain("alloc", 10);

        // Boundary indices 0 and 255.
        e = '0; put(0, 8'd0, 8'h0, 1'b1, 1'b1, 1'b0, 32'h0); put(1, 8'd255, 8'h3C, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF); sb.push_back(e);
        drv(0, 8'd0, 8'h0, 1'b1, 1'b1, 1'b0, 32'h0);
        drv(1, 8'd255, 8'h3C, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        step();
        drain("edges", 10);

        // Fill: same index everywhere, so one record leaves per cycle while two arrive.
        ec = 0; seq = 0;
        for (int c = 0; c < 10; c++) begin
            rm = ((8 - ec) >= 2);
            chk($sformatf("fill_ready_%0d", c), 128'(cm_ready_o), 128'(rm));
            drv(0, 8'd7, 8'h0, 1'b1, 1'b0, 1'b0, 32'h100 + 32'(seq));
            drv(1, 8'd7, 8'h0, 1'b1, 1'b0, 1'b0, 32'h101 + 32'(seq));
            if (rm) begin
                e = '0; put(0, 8'd7, 8'h0, 1'b1, 1'b0, 1'b0, 32'h100 + 32'(seq)); sb.push_back(e);
                e = '0; put(0, 8'd7, 8'h0, 1'b1, 1'b0, 1'b0, 32'h101 + 32'(seq)); sb.push_back(e);
            end
            seq += 2;
            dq = (ec > 0) ? 1 : 0;
            ec = ec + (rm ? 2 : 0) - dq;
            step();
        end
        drain("fill", 40);
        chk("fill_busy_idle", 128'(busy_o), 128'd0);

        // Reset landing between enqueue and first dequeue discards the records.
        drv(0, 8'd60, 8'h0, 1'b1, 1'b1, 1'b0, 32'h0);
        drv(1, 8'd60, 8'h0, 1'b1, 1'b0, 1'b0, 32'h9);
        step();
        #2 rst_ni = 1'b0;
        @(negedge clk_i);
        chk("flight_rst_ud", 128'(snap_now()), 128'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        repeat (4) @(posedge clk_i);
        #1;
        chk("flight_rst_busy", 128'(busy_o), 128'd0);
        chk("flight_rst_ready", 128'(cm_ready_o), 128'd1);

`ifdef VTAGE_U_DECAY_EN
        // Four allocations wrap the 2-bit counter and start the walk.
        e = '0; put(0, 8'd100, 8'h11, 1'b0, 1'b0, 1'b1, 32'h1); put(1, 8'd101, 8'h22, 1'b0, 1'b0, 1'b1, 32'h2); sb.push_back(e);
        drv(0, 8'd100, 8'h11, 1'b0, 1'b0, 1'b1, 32'h1);
        drv(1, 8'd101, 8'h22, 1'b0, 1'b0, 1'b1, 32'h2);
        step();
        e = '0; put(0, 8'd102, 8'h33, 1'b0, 1'b0, 1'b1, 32'h3); put(1, 8'd103, 8'h44, 1'b0, 1'b0, 1'b1, 32'h4); sb.push_back(e);
        drv(0, 8'd102, 8'h33, 1'b0, 1'b0, 1'b1, 32'h3);
        drv(1, 8'd103, 8'h44, 1'b0, 1'b0, 1'b1, 32'h4);
        step();
        for (int k = 0; k < 128; k++) begin
            e = '0;
            e.idx = {8'(2*k + 1), 8'(2*k)};
            e.du  = '1;
            sb.push_back(e);
        end
        e = '0; put(0, 8'd50, 8'h0, 1'b1, 1'b1, 1'b0, 32'h0); sb.push_back(e);
        drv(0, 8'd50, 8'h0, 1'b1, 1'b1, 1'b0, 32'h0);
        step();
        repeat (20) @(posedge clk_i);
        #1;
        chk("decay_busy", 128'(busy_o), 128'd1);
        drain("decay", 300);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
